// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier with a start/done handshake. It handles one multiplier
// bit per cycle and stops early once the remaining multiplier bits are all zero.
module seq_shift_add_mult #(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_q,   state_d;
    logic [2*WIDTH-1:0] a_sh_q,    a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,    b_sh_d;
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic               neg_q,     neg_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_next;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;

        // A most-negative operand maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
        a_mag  = (SIGNED && a[WIDTH-1]) ? -a : a;
        b_mag  = (SIGNED && b[WIDTH-1]) ? -b : b;
        b_next = b_sh_q >> 1;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_sh_d  = {{WIDTH{1'b0}}, a_mag};
                    b_sh_d  = b_mag;
                    acc_d   = '0;
                    cnt_d   = '0;
                    neg_d   = SIGNED ? (a[WIDTH-1] ^ b[WIDTH-1]) : 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (b_sh_q[0]) begin
                    acc_d = acc_q + a_sh_q;
                end
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_next;
                cnt_d  = cnt_q + CW'(1);
                if (b_next == '0 || cnt_q == CW'(WIDTH - 1)) begin
                    if (SIGNED) begin
                        state_d = S_SIGN;
                    end else begin
                        state_d   = S_DONE;
                        product_d = acc_d;
                    end
                end
            end
            S_SIGN: begin
                acc_d     = neg_q ? -acc_q : acc_q;
                state_d   = S_DONE;
                product_d = acc_d;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == S_RUN) || (state_q == S_SIGN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule
